// File: rtl/serial_rx_frame.sv
// Serial-to-parallel frame receiver: start bit, DATA_W data bits MSB first,
// optional even/odd parity, low stop bit, held output word with valid/ack.
module serial_rx_frame #(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              SDin,
   input  logic              PDack,
   output logic [DATA_W-1:0] PDout,
   output logic              PDvalid,
   output logic              ParErr,
   output logic              FrmErr,
   output logic              Overrun
);

   localparam int               CNT_W    = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               SDin_d1;
   logic               start_det;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  SR;
   logic               par_bit;

   logic               vld_p0;
   logic [DATA_W-1:0]  data_p0;
   logic               perr_p0;
   logic               ferr_p0;

   function automatic logic exp_parity(input logic [DATA_W-1:0] d);
      return (PARITY_ODD != 0) ? ~(^d) : (^d);
   endfunction

   function automatic logic parity_err(input logic [DATA_W-1:0] d, input logic p);
      return (PARITY_EN != 0) && (p != exp_parity(d));
   endfunction

   // SDin_d1 resets high so a line already high at reset release is not a start
   assign start_det = (state == IDLE) && SDin && !SDin_d1;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_det) state_nxt = DATA;
         end
         DATA: begin
            if (cnt == LAST_BIT) state_nxt = (PARITY_EN != 0) ? PAR : STOP;
         end
         PAR:  state_nxt = STOP;
         STOP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         SDin_d1 <= 1'b1;
         cnt     <= '0;
         SR      <= '0;
         par_bit <= 1'b0;
      end else begin
         SDin_d1 <= SDin;
         case (state)
            IDLE: begin
               if (start_det) cnt <= '0;
            end
            DATA: begin
               SR  <= {SR[DATA_W-2:0], SDin};
               cnt <= cnt + CNT_W'(1);
            end
            PAR:  par_bit <= SDin;
            default: ;
         endcase
      end
   end

   // Stage p0: frame evaluated in the STOP cycle, delivered one edge later
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= (state == STOP);
      end
   end

   always_ff @(posedge Clk) begin
      if (state == STOP) begin
         data_p0 <= SR;
         perr_p0 <= parity_err(SR, par_bit);
         ferr_p0 <= SDin;
      end
   end

   // Output stage: held frame with valid/ack; a frame arriving on a full,
   // unacknowledged holder is dropped and flagged
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         PDout   <= '0;
         PDvalid <= 1'b0;
         ParErr  <= 1'b0;
         FrmErr  <= 1'b0;
         Overrun <= 1'b0;
      end else begin
         Overrun <= 1'b0;
         if (vld_p0) begin
            if (!PDvalid || PDack) begin
               PDout   <= data_p0;
               ParErr  <= perr_p0;
               FrmErr  <= ferr_p0;
               PDvalid <= 1'b1;
            end else begin
               Overrun <= 1'b1;
            end
         end else if (PDack && PDvalid) begin
            PDvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_rx_frame.sv
// Bench for serial_rx_frame: table-driven frames with a scoreboard queue,
// plus hand sequences for overrun, reset, 5-bit no-parity and odd parity.
module tb_serial_rx_frame;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic       Rst_n;
   logic       sd8, ack8, sd5, ack5, sdo, acko;
   logic [7:0] pd8, pdo;
   logic [4:0] pd5;
   logic       v8, pe8, fe8, ov8;
   logic       v5, pe5, fe5, ov5;
   logic       vo, peo, feo, ovo;

   serial_rx_frame #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) u8 (
      .Clk(Clk), .Rst_n(Rst_n), .SDin(sd8), .PDack(ack8), .PDout(pd8),
      .PDvalid(v8), .ParErr(pe8), .FrmErr(fe8), .Overrun(ov8));

   serial_rx_frame #(.DATA_W(5), .PARITY_EN(0), .PARITY_ODD(0)) u5 (
      .Clk(Clk), .Rst_n(Rst_n), .SDin(sd5), .PDack(ack5), .PDout(pd5),
      .PDvalid(v5), .ParErr(pe5), .FrmErr(fe5), .Overrun(ov5));

   serial_rx_frame #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1)) uo (
      .Clk(Clk), .Rst_n(Rst_n), .SDin(sdo), .PDack(acko), .PDout(pdo),
      .PDvalid(vo), .ParErr(peo), .FrmErr(feo), .Overrun(ovo));

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stp;
      logic       perr;
      logic       ferr;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv(input int which, input logic b);
      case (which)
         0:       sd8 = b;
         1:       sd5 = b;
         default: sdo = b;
      endcase
   endtask

   task automatic set_ack(input int which, input logic b);
      case (which)
         0:       ack8 = b;
         1:       ack5 = b;
         default: acko = b;
      endcase
   endtask

   function automatic logic valid_of(input int which);
      return (which == 2) ? vo : v8;
   endfunction

   function automatic logic [7:0] data_of(input int which);
      return (which == 2) ? pdo : pd8;
   endfunction

   // Drives start, 8 data bits MSB first, parity and stop on successive cycles
   task automatic send8(input int which, input logic [7:0] d, input logic par, input logic stp);
      @(negedge Clk) drv(which, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         @(negedge Clk) drv(which, d[i]);
      end
      @(negedge Clk) drv(which, par);
      @(negedge Clk) drv(which, stp);
   endtask

   task automatic push(input logic [7:0] d, input logic perr, input logic ferr);
      exp_t e;
      e.data = d;
      e.perr = perr;
      e.ferr = ferr;
      sb.push_back(e);
   endtask

   task automatic pop_check(input int which, input string name);
      exp_t e;
      logic pe, fe;
      pe = (which == 2) ? peo : pe8;
      fe = (which == 2) ? feo : fe8;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got data %0h", name, data_of(which));
         return;
      end
      e = sb.pop_front();
      chk({name, ".valid"}, valid_of(which), 1);
      chk({name, ".data"}, data_of(which), e.data);
      chk({name, ".perr"}, pe, e.perr);
      chk({name, ".ferr"}, fe, e.ferr);
   endtask

   // Line idles after the stop bit; output must not appear before t+11
   task automatic finish_frame(input int which, input string name);
      @(negedge Clk) drv(which, 1'b0);
      chk({name, ".early"}, valid_of(which), 0);
      @(negedge Clk);
      pop_check(which, name);
   endtask

   task automatic ack_clear(input int which, input logic [7:0] held, input string name);
      set_ack(which, 1'b1);
      @(negedge Clk) set_ack(which, 1'b0);
      chk({name, ".ackvalid"}, valid_of(which), 0);
      chk({name, ".ackdata"}, data_of(which), held);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[5] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1};

      Rst_n = 1'b0;
      sd8 = 1'b0; sd5 = 1'b0; sdo = 1'b0;
      ack8 = 1'b0; ack5 = 1'b0; acko = 1'b0;
      #12;
      chk("rst.pdout", pd8, 0);
      chk("rst.valid", v8, 0);
      chk("rst.perr", pe8, 0);
      chk("rst.ferr", fe8, 0);
      chk("rst.ovr", ov8, 0);
      chk("rst.valid5", v5, 0);
      chk("rst.valido", vo, 0);
      @(negedge Clk) Rst_n = 1'b1;
      repeat (2) @(negedge Clk);

      // Acknowledge with nothing held is ignored
      ack8 = 1'b1;
      @(negedge Clk) ack8 = 1'b0;
      chk("idle_ack.valid", v8, 0);
      chk("idle_ack.ovr", ov8, 0);

      for (int i = 0; i < 6; i++) begin
         push(vt[i].data, vt[i].perr, vt[i].ferr);
         send8(0, vt[i].data, vt[i].par, vt[i].stp);
         finish_frame(0, $sformatf("vec%0d", i));
         ack_clear(0, vt[i].data, $sformatf("vec%0d", i));
         @(negedge Clk);
      end

      // Overrun: second frame back-to-back with nothing acknowledged
      push(8'h11, 1'b0, 1'b0);
      send8(0, 8'h11, 1'b0, 1'b0);
      send8(0, 8'h22, 1'b0, 1'b0);
      @(negedge Clk) sd8 = 1'b0;
      chk("ovr.early", ov8, 0);
      @(negedge Clk);
      chk("ovr.pulse", ov8, 1);
      pop_check(0, "ovr.held");
      @(negedge Clk);
      chk("ovr.pulse_end", ov8, 0);
      chk("ovr.still_valid", v8, 1);
      ack_clear(0, 8'h11, "ovr");

      // Acknowledge in the completion cycle takes the new word, no overrun
      send8(0, 8'h11, 1'b0, 1'b0);
      push(8'h22, 1'b0, 1'b0);
      send8(0, 8'h22, 1'b0, 1'b0);
      @(negedge Clk) begin sd8 = 1'b0; ack8 = 1'b1; end
      @(negedge Clk) ack8 = 1'b0;
      chk("ackload.ovr", ov8, 0);
      pop_check(0, "ackload");
      ack_clear(0, 8'h22, "ackload");

      // Reset mid-frame with a frame held
      push(8'hAA, 1'b0, 1'b0);
      send8(0, 8'hAA, 1'b0, 1'b0);
      finish_frame(0, "pre_rst");
      @(negedge Clk) sd8 = 1'b1;
      @(negedge Clk) sd8 = 1'b1;
      @(negedge Clk) sd8 = 1'b0;
      @(negedge Clk) sd8 = 1'b1;
      @(negedge Clk) sd8 = 1'b1;
      #2 Rst_n = 1'b0;
      #1;
      chk("midrst.pdout", pd8, 0);
      chk("midrst.valid", v8, 0);
      chk("midrst.perr", pe8, 0);
      chk("midrst.ferr", fe8, 0);
      chk("midrst.ovr", ov8, 0);
      @(negedge Clk) Rst_n = 1'b1;
      repeat (14) @(negedge Clk);
      chk("high_release.valid", v8, 0);
      sd8 = 1'b0;
      push(8'h5A, 1'b0, 1'b0);
      send8(0, 8'h5A, 1'b0, 1'b0);
      finish_frame(0, "post_rst");
      ack_clear(0, 8'h5A, "post_rst");

      // 5-bit, no parity: output at t+7
      @(negedge Clk) sd5 = 1'b1;
      @(negedge Clk) sd5 = 1'b1;
      @(negedge Clk) sd5 = 1'b0;
      @(negedge Clk) sd5 = 1'b1;
      @(negedge Clk) sd5 = 1'b1;
      @(negedge Clk) sd5 = 1'b0;
      @(negedge Clk) sd5 = 1'b0;
      @(negedge Clk) sd5 = 1'b0;
      chk("w5.early", v5, 0);
      @(negedge Clk);
      chk("w5.valid", v5, 1);
      chk("w5.data", pd5, 5'b10110);
      chk("w5.perr", pe5, 0);
      chk("w5.ferr", fe5, 0);
      ack5 = 1'b1;
      @(negedge Clk) ack5 = 1'b0;
      chk("w5.ack", v5, 0);
      @(negedge Clk) sd5 = 1'b1;
      @(negedge Clk) sd5 = 1'b0;
      @(negedge Clk) sd5 = 1'b1;
      @(negedge Clk) sd5 = 1'b0;
      @(negedge Clk) sd5 = 1'b0;
      @(negedge Clk) sd5 = 1'b1;
      @(negedge Clk) sd5 = 1'b1;
      @(negedge Clk) sd5 = 1'b0;
      @(negedge Clk);
      chk("w5b.data", pd5, 5'b01001);
      chk("w5b.perr", pe5, 0);
      chk("w5b.ferr", fe5, 1);

      // Odd parity on an all-zero word
      push(8'h00, 1'b0, 1'b0);
      send8(2, 8'h00, 1'b1, 1'b0);
      finish_frame(2, "odd_ok");
      ack_clear(2, 8'h00, "odd_ok");
      push(8'h00, 1'b1, 1'b0);
      send8(2, 8'h00, 1'b0, 1'b0);
      finish_frame(2, "odd_bad");
      ack_clear(2, 8'h00, "odd_bad");

      chk("sb.drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
